// File: rtl/apb_mem_bridge.sv
// APB3 completer bridging to a 16x32 variable-latency memory request port.
// Decodes word addresses, bounds memory wait with a timeout, counts error responses.
module apb_mem_bridge #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned TIMEOUT = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              psel_i,
  input  logic              penable_i,
  input  logic              pwrite_i,
  input  logic [ADDR_W-1:0] paddr_i,
  input  logic [31:0]       pwdata_i,
  output logic              pready_o,
  output logic [31:0]       prdata_o,
  output logic              pslverr_o,
  output logic              req_o,
  output logic              req_rnw_o,
  output logic [3:0]        req_addr_o,
  output logic [31:0]       req_wdata_o,
  input  logic              req_ready_i,
  input  logic [31:0]       req_rdata_i,
  output logic [7:0]        err_cnt_o
);

  localparam int unsigned TIMER_W = 8;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_ERROR  = 2'd2
  } state_t;

  state_t              state;
  logic                rnw;
  logic                req;
  logic [3:0]          addr;
  logic [31:0]         wdata;
  logic [TIMER_W-1:0]  timer;
  logic [7:0]          err_cnt;

  logic setup;
  logic dec_err;
  logic tmo;

  assign setup   = psel_i & ~penable_i;
  assign dec_err = (paddr_i[1:0] != 2'b00) | (paddr_i[ADDR_W-1:6] != '0);
  assign tmo     = (timer == TIMER_W'(TIMEOUT - 1));

  // APB response is combinational so a ready memory completes with zero wait states.
  always_comb begin
    pready_o  = 1'b0;
    pslverr_o = 1'b0;
    prdata_o  = '0;
    case (state)
      S_ACCESS: begin
        pready_o  = req_ready_i | tmo;
        pslverr_o = tmo & ~req_ready_i;
        if (rnw & req_ready_i) prdata_o = req_rdata_i;
      end
      S_ERROR: begin
        pready_o  = 1'b1;
        pslverr_o = 1'b1;
      end
      default: ;
    endcase
  end

  // Every completion returns to IDLE, which guarantees a low cycle on req between requests.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      rnw     <= 1'b0;
      req     <= 1'b0;
      addr    <= '0;
      wdata   <= '0;
      timer   <= '0;
      err_cnt <= '0;
    end else begin
      if (pready_o & pslverr_o & (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;
      case (state)
        S_IDLE: begin
          if (setup) begin
            rnw   <= ~pwrite_i;
            addr  <= paddr_i[5:2];
            wdata <= pwdata_i;
            timer <= '0;
            if (dec_err) begin
              state <= S_ERROR;
            end else begin
              state <= S_ACCESS;
              req   <= 1'b1;
            end
          end
        end
        S_ACCESS: begin
          timer <= timer + TIMER_W'(1);
          if (pready_o || !psel_i) begin
            state <= S_IDLE;
            req   <= 1'b0;
          end
        end
        S_ERROR: state <= S_IDLE;
        default: begin
          state <= S_IDLE;
          req   <= 1'b0;
        end
      endcase
    end
  end

  assign req_o       = req;
  assign req_rnw_o   = rnw;
  assign req_addr_o  = addr;
  assign req_wdata_o = wdata;
  assign err_cnt_o   = err_cnt;

endmodule

// File: tb/tb_apb_mem_bridge.sv
// Directed bench for apb_mem_bridge: variable-latency memory model plus expected-response queue.
module tb_apb_mem_bridge;

  localparam int unsigned TMO = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata;
  logic        pready, pslverr;
  logic [31:0] prdata;
  logic        req, req_rnw, req_ready;
  logic [3:0]  req_addr;
  logic [31:0] req_wdata, req_rdata;
  logic [7:0]  err_cnt;

  apb_mem_bridge #(.ADDR_W(32), .TIMEOUT(TMO)) dut (
    .clk        (clk),
    .reset      (reset),
    .psel_i     (psel),
    .penable_i  (penable),
    .pwrite_i   (pwrite),
    .paddr_i    (paddr),
    .pwdata_i   (pwdata),
    .pready_o   (pready),
    .prdata_o   (prdata),
    .pslverr_o  (pslverr),
    .req_o      (req),
    .req_rnw_o  (req_rnw),
    .req_addr_o (req_addr),
    .req_wdata_o(req_wdata),
    .req_ready_i(req_ready),
    .req_rdata_i(req_rdata),
    .err_cnt_o  (err_cnt)
  );

  always #5 clk = ~clk;

  // Memory model: latency counter restarts whenever req was low at the previous edge.
  logic [31:0] mem [16];
  int          mem_cnt = 0;
  int          lat = 0;
  assign req_ready = req && (lat != 0) && (mem_cnt == lat - 1);
  assign req_rdata = mem[req_addr];
  always @(posedge clk) begin
    mem_cnt <= req ? mem_cnt + 1 : 0;
    if (req && req_ready && !req_rnw) mem[req_addr] <= req_wdata;
  end

  typedef struct {
    logic        err;
    logic [31:0] data;
    int          cycles;
    int          hi;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] ref_mem [16];
  int          exp_err = 0;
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One APB transfer; called at posedge+1 and returns at posedge+1 after completion.
  task automatic xfer(input bit wr, input logic [31:0] a, input logic [31:0] d, input int l);
    exp_t e, got;
    bit   derr, tmo_x, seen, ok;
    int   cyc, hi;
    derr     = (a[1:0] != 2'b00) || (a[31:6] != 26'd0);
    tmo_x    = !derr && (l == 0 || l > int'(TMO));
    e.err    = derr || tmo_x;
    e.cycles = derr ? 1 : (tmo_x ? int'(TMO) : l);
    e.hi     = derr ? 0 : e.cycles;
    e.data   = (!wr && !e.err) ? ref_mem[a[5:2]] : 32'd0;
    if (wr && !e.err) ref_mem[a[5:2]] = d;
    sb.push_back(e);
    lat = l; psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
    @(negedge clk);
    check("setup_req", 32'(req), 32'd0);
    check("setup_pready", 32'(pready), 32'd0);
    check("err_cnt", 32'(err_cnt), 32'(exp_err));
    @(posedge clk); #1 penable = 1'b1;
    cyc = 0; hi = 0; ok = 1'b1; seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      cyc++;
      if (req) begin
        hi++;
        if (req_addr !== a[5:2] || req_rnw !== !wr || (wr && req_wdata !== d)) ok = 1'b0;
      end
      if (pready) begin
        seen = 1'b1;
        got = sb.pop_front();
        check("pslverr", 32'(pslverr), 32'(got.err));
        check("prdata", prdata, got.data);
        check("latency", 32'(cyc), 32'(got.cycles));
        check("req_high_cycles", 32'(hi), 32'(got.hi));
        check("req_fields_stable", 32'(ok), 32'd1);
        if (got.err && exp_err < 255) exp_err++;
      end
      @(posedge clk); #1;
    end
    check("pready_seen", 32'(seen), 32'd1);
    if (!seen) void'(sb.pop_front());
    psel = 1'b0; penable = 1'b0;
  endtask

  initial begin
    reset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
    for (int i = 0; i < 16; i++) ref_mem[i] = 32'd0;
    repeat (3) @(negedge clk);
    check("rst_req", 32'(req), 32'd0);
    check("rst_pready", 32'(pready), 32'd0);
    check("rst_pslverr", 32'(pslverr), 32'd0);
    check("rst_err_cnt", 32'(err_cnt), 32'd0);
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk); #1;

    // Write then read with latency 5 and 3; boundary latency 8 succeeds.
    xfer(1'b1, 32'h14, 32'hDEADBEEF, 5);
    xfer(1'b0, 32'h14, 32'h0, 3);
    xfer(1'b1, 32'h3C, 32'hA5A5_0F0F, int'(TMO));
    xfer(1'b0, 32'h3C, 32'h0, 2);

    // Zero-wait back-to-back transfers.
    xfer(1'b1, 32'h00, 32'h1234_5678, 1);
    xfer(1'b0, 32'h00, 32'h0, 1);
    xfer(1'b0, 32'h14, 32'h0, 1);

    // Decode errors: misaligned, beyond 16 words, high address bit.
    xfer(1'b1, 32'h41, 32'h1, 1);
    xfer(1'b0, 32'h40, 32'h0, 1);
    xfer(1'b0, 32'h8000_0000, 32'h0, 1);
    xfer(1'b0, 32'h02, 32'h0, 1);

    // Memory never ready: forced error on the last ACCESS cycle.
    xfer(1'b1, 32'h08, 32'hCAFE_F00D, 0);
    xfer(1'b0, 32'h3C, 32'h0, 4);

    // Reset during a read whose memory data is already on the bus.
    lat = 3; psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h14;
    @(posedge clk); #1 penable = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("pre_rst_pready", 32'(pready), 32'd1);
    check("pre_rst_prdata", prdata, ref_mem[5]);
    reset = 1'b1;
    #1;
    check("async_rst_req", 32'(req), 32'd0);
    check("async_rst_pready", 32'(pready), 32'd0);
    check("async_rst_prdata", prdata, 32'd0);
    check("async_rst_err_cnt", 32'(err_cnt), 32'd0);
    exp_err = 0;
    psel = 1'b0; penable = 1'b0;
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk); #1;
    xfer(1'b0, 32'h14, 32'h0, 2);
    xfer(1'b0, 32'h30, 32'h0, 1);

    // Abort: psel dropped during ACCESS with the memory stalled.
    lat = 0; psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h20; pwdata = 32'h5555_AAAA;
    @(posedge clk); #1 penable = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1 psel = 1'b0; penable = 1'b0;
    @(negedge clk);
    check("abort_pready", 32'(pready), 32'd0);
    @(negedge clk);
    check("abort_req_low", 32'(req), 32'd0);
    check("abort_pready_idle", 32'(pready), 32'd0);
    check("abort_err_cnt", 32'(err_cnt), 32'(exp_err));
    @(posedge clk); #1;
    xfer(1'b0, 32'h00, 32'h0, 2);

    // Saturation of the error counter.
    for (int i = 0; i < 260; i++) xfer(1'b0, 32'h40 + 32'(i * 4), 32'h0, 1);
    @(negedge clk);
    check("err_cnt_saturated", 32'(err_cnt), 32'd255);
    @(posedge clk); #1;
    xfer(1'b0, 32'h01, 32'h0, 1);
    xfer(1'b0, 32'h3C, 32'h0, 1);
    @(negedge clk);
    check("err_cnt_held", 32'(err_cnt), 32'(exp_err));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
